// File: rtl/dsc_pkg.sv
// Shared definitions for the caminho_saida path-reversal block:
// default sizing constants and the controller state encoding.
package dsc_pkg;

  localparam int CAMINHO_ADDR_WIDTH = 8;
  localparam int CAMINHO_MAX        = 64;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CARREGANDO = 2'd1,
    ENVIANDO   = 2'd2,
    ERRO       = 2'd3
  } caminho_saida_estado_t;

endpackage

// File: rtl/caminho_saida_if.sv
// Stream bundle for caminho_saida: the upstream path-node stream
// (destination first) and the downstream forward-order stream.
// The slave modport is the block's view; master is the environment's.
interface caminho_saida_if
  import dsc_pkg::*;
#(
  parameter int ADDR_WIDTH = CAMINHO_ADDR_WIDTH
);

  logic                  caminho_valid_in;
  logic [ADDR_WIDTH-1:0] caminho_addr_in;
  logic                  caminho_fim_in;
  logic                  caminho_ready_out;

  logic                  saida_valid_out;
  logic [ADDR_WIDTH-1:0] saida_addr_out;
  logic                  saida_ultimo_out;
  logic                  saida_ready_in;

  modport slave (
    input  caminho_valid_in,
    input  caminho_addr_in,
    input  caminho_fim_in,
    output caminho_ready_out,
    output saida_valid_out,
    output saida_addr_out,
    output saida_ultimo_out,
    input  saida_ready_in
  );

  modport master (
    output caminho_valid_in,
    output caminho_addr_in,
    output caminho_fim_in,
    input  caminho_ready_out,
    input  saida_valid_out,
    input  saida_addr_out,
    input  saida_ultimo_out,
    output saida_ready_in
  );

endinterface

// File: rtl/caminho_saida_lifo_mem.sv
// caminho_lifo_mem: node storage for the path reversal. Plain register
// array with one synchronous write port and one asynchronous read port,
// so the top of the stack is visible in the same cycle the pointer moves.
// Contents are deliberately not reset; the pointer alone defines validity.
module caminho_lifo_mem #(
  parameter int ADDR_WIDTH   = 8,
  parameter int PROFUNDIDADE = 64,
  parameter int IDX_W        = $clog2(PROFUNDIDADE)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [ADDR_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [ADDR_WIDTH-1:0] rd_data
);

  logic [ADDR_WIDTH-1:0] mem [PROFUNDIDADE];

  // Store an accepted upstream node at the slot chosen by the controller.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/caminho_saida.sv
// caminho_saida: receives a routed path destination-first, stacks it in a
// LIFO and replays it source-first with a valid/ready handshake.
// Optional feature: define CAMINHO_SAIDA_COMPRIMENTO_EN to add the
// comprimento_out port reporting the node count of the path being sent.
module caminho_saida
  import dsc_pkg::*;
#(
  parameter int ADDR_WIDTH  = CAMINHO_ADDR_WIDTH,
  parameter int MAX_CAMINHO = CAMINHO_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  caminho_saida_if.slave       bus,
  input  logic                 limpar_in,
  output logic                 erro_out,
  output logic                 pronto_out
`ifdef CAMINHO_SAIDA_COMPRIMENTO_EN
  ,
  output logic [$clog2(MAX_CAMINHO+1)-1:0] comprimento_out
`endif
);

  localparam int PTR_W = $clog2(MAX_CAMINHO + 1);
  localparam int IDX_W = $clog2(MAX_CAMINHO);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(MAX_CAMINHO);
  localparam logic [PTR_W-1:0] PTR_UM  = PTR_W'(1);

  caminho_saida_estado_t estado;
  logic [PTR_W-1:0]      ptr;

  logic                  aceita;
  logic                  handshake;
  logic                  cheio;
  logic                  mem_wr_en;
  logic [IDX_W-1:0]      mem_wr_idx;
  logic [IDX_W-1:0]      mem_rd_idx;
  logic [ADDR_WIDTH-1:0] mem_rd_data;

  // Handshake qualifiers; the stack is full when ptr reaches the depth,
  // and a word offered then is an overflow rather than a store.
  always_comb begin
    bus.caminho_ready_out = (estado == OCIOSO) || (estado == CARREGANDO);
    aceita     = bus.caminho_valid_in && bus.caminho_ready_out;
    cheio      = (ptr == PTR_MAX);
    handshake  = (estado == ENVIANDO) && bus.saida_ready_in;
    mem_wr_en  = aceita && !cheio && !rst && !limpar_in;
    mem_wr_idx = (estado == OCIOSO) ? '0 : IDX_W'(ptr);
    mem_rd_idx = IDX_W'(ptr - PTR_UM);
  end

  // Output view: top of stack while sending, zeros otherwise.
  always_comb begin
    bus.saida_valid_out  = (estado == ENVIANDO);
    bus.saida_addr_out   = (estado == ENVIANDO) ? mem_rd_data : '0;
    bus.saida_ultimo_out = (estado == ENVIANDO) && (ptr == PTR_UM);
  end

  caminho_lifo_mem #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PROFUNDIDADE(MAX_CAMINHO),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (mem_wr_en),
    .wr_idx (mem_wr_idx),
    .wr_data(bus.caminho_addr_in),
    .rd_idx (mem_rd_idx),
    .rd_data(mem_rd_data)
  );

  // Controller: load until fim, replay by popping, trap overflow in ERRO;
  // limpar_in behaves like reset and wins over any coincident handshake.
  always_ff @(posedge clk) begin
    if (rst || limpar_in) begin
      estado     <= OCIOSO;
      ptr        <= '0;
      erro_out   <= 1'b0;
      pronto_out <= 1'b0;
    end else begin
      pronto_out <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            ptr    <= PTR_UM;
            estado <= bus.caminho_fim_in ? ENVIANDO : CARREGANDO;
          end
        end
        CARREGANDO: begin
          if (aceita) begin
            if (cheio) begin
              erro_out <= 1'b1;
              estado   <= ERRO;
            end else begin
              ptr <= ptr + PTR_UM;
              if (bus.caminho_fim_in) begin
                estado <= ENVIANDO;
              end
            end
          end
        end
        ENVIANDO: begin
          if (handshake) begin
            ptr <= ptr - PTR_UM;
            if (ptr == PTR_UM) begin
              estado     <= OCIOSO;
              pronto_out <= 1'b1;
            end
          end
        end
        ERRO: begin
          estado <= ERRO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

`ifdef CAMINHO_SAIDA_COMPRIMENTO_EN
  // Path length captured as the stack switches to sending; cleared when a
  // new path starts loading, on abort or on reset.
  always_ff @(posedge clk) begin
    if (rst || limpar_in) begin
      comprimento_out <= '0;
    end else if (estado == OCIOSO && aceita) begin
      comprimento_out <= bus.caminho_fim_in ? PTR_UM : '0;
    end else if (estado == CARREGANDO && aceita && !cheio && bus.caminho_fim_in) begin
      comprimento_out <= ptr + PTR_UM;
    end
  end
`endif

endmodule
